usb_tx_wire_arbiter_n: RTL and testbench

- N-requester arbiter and multiplexer for the USB transmit wire. Generalises the two-source (processTxByte/SIE) wire arbiter to NUM_REQ sources.
- Adds selectable fixed or round-robin priority, a grant-hold watchdog, and write-enable gating.
- Sits between the transmit-side requesters (SIE transmitter, processTxByte, test/resume generators) and the USB wire buffer/serialiser.

---
 rtl/usb_tx_wire_arbiter_n_if.sv | 37 +++
 rtl/usb_tx_wire_arbiter_n.sv | 142 ++++++++++++++
 tb/tb_usb_tx_wire_arbiter_n.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/usb_tx_wire_arbiter_n_if.sv
// Bundle of the requester lanes and the wire-side signals around the
// transmit wire arbiter. The master side is the requesters plus the wire
// buffer. The slave side is the arbiter itself.
interface usb_tx_wire_arbiter_n_if #(
    parameter int NUM_REQ = 2,
    parameter int BITS_W  = 2
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        TxReq;
    logic [NUM_REQ-1:0]        TxGnt;
    logic [NUM_REQ*BITS_W-1:0] TxDataIn;
    logic [NUM_REQ-1:0]        TxCtrlIn;
    logic [NUM_REQ-1:0]        TxFSRateIn;
    logic [NUM_REQ-1:0]        TxWEnIn;
    logic                      USBWireRdyIn;
    logic [BITS_W-1:0]         TxBits;
    logic                      TxCtl;
    logic                      TxFSRate;
    logic                      USBWireWEn;
    logic                      USBWireRdyOut;
    logic [ID_W-1:0]           GntId;
    logic                      GntActive;
    logic                      HoldTimeout;

    modport master (
        output TxReq, TxDataIn, TxCtrlIn, TxFSRateIn, TxWEnIn, USBWireRdyIn,
        input  TxGnt, TxBits, TxCtl, TxFSRate, USBWireWEn, USBWireRdyOut,
               GntId, GntActive, HoldTimeout
    );

    modport slave (
        input  TxReq, TxDataIn, TxCtrlIn, TxFSRateIn, TxWEnIn, USBWireRdyIn,
        output TxGnt, TxBits, TxCtl, TxFSRate, USBWireWEn, USBWireRdyOut,
               GntId, GntActive, HoldTimeout
    );
endinterface

// File: rtl/usb_tx_wire_arbiter_n.sv
// N-way arbiter and multiplexer for the USB transmit wire.
// The grant is registered. Priority is either fixed or round-robin.
// An optional watchdog revokes a grant that is held too long. After a
// revoke, the requester stays locked out until it drops its request.
module usb_tx_wire_arbiter_n #(
    parameter int NUM_REQ     = 2,
    parameter int BITS_W      = 2,
    parameter int ROUND_ROBIN = 0,
    parameter int MAX_HOLD    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    usb_tx_wire_arbiter_n_if.slave   bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic [1:0] {INIT, IDLE, GRANT} state_t;

    state_t             state, stateNext;
    logic [NUM_REQ-1:0] gnt, gntNext;
    logic [ID_W-1:0]    gntId, gntIdNext;
    logic [ID_W-1:0]    ptr, ptrNext;
    logic [CNT_W-1:0]   holdCnt, holdCntNext;
    logic [NUM_REQ-1:0] lockout, lockoutNext;
    logic               holdTimeout, holdTimeoutNext;

    logic [NUM_REQ-1:0] eligible;
    logic [ID_W-1:0]    winner;
    logic               found;
    logic               timeoutHit;
    logic [BITS_W-1:0]  lane [NUM_REQ];

    // Unpack the flat data bus into one lane per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane[gi] = bus.TxDataIn[gi*BITS_W +: BITS_W];
        end
    endgenerate

    assign eligible   = bus.TxReq & ~lockout;
    assign timeoutHit = (MAX_HOLD != 0) && (state == GRANT) &&
                        bus.TxReq[gntId] && (holdCnt == HOLD_LAST);

    // Winner search: lowest index, or the first index above the last grantee.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        if (ROUND_ROBIN != 0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (!found && eligible[(int'(ptr) + k) % NUM_REQ]) begin
                    winner = ID_W'((int'(ptr) + k) % NUM_REQ);
                    found  = 1'b1;
                end
            end
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    winner = ID_W'(i);
                end
            end
        end
    end

    // State register and arbitration bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            gnt         <= '0;
            gntId       <= '0;
            ptr         <= ID_W'(NUM_REQ - 1);
            holdCnt     <= '0;
            lockout     <= '0;
            holdTimeout <= 1'b0;
        end else begin
            state       <= stateNext;
            gnt         <= gntNext;
            gntId       <= gntIdNext;
            ptr         <= ptrNext;
            holdCnt     <= holdCntNext;
            lockout     <= lockoutNext;
            holdTimeout <= holdTimeoutNext;
        end
    end

    // Next-state logic. IDLE always separates two grants.
    always_comb begin
        stateNext = state;
        case (state)
            INIT:    stateNext = IDLE;
            IDLE:    if (|eligible) stateNext = GRANT;
            GRANT:   if (!bus.TxReq[gntId] || timeoutHit) stateNext = IDLE;
            default: stateNext = INIT;
        endcase
    end

    // Next values for the grant, pointer, watchdog and lockout registers.
    always_comb begin
        gntNext         = gnt;
        gntIdNext       = gntId;
        ptrNext         = ptr;
        holdCntNext     = holdCnt;
        holdTimeoutNext = 1'b0;
        // A lockout is released as soon as its requester lets go.
        lockoutNext     = lockout & bus.TxReq;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    gntNext         = '0;
                    gntNext[winner] = 1'b1;
                    gntIdNext       = winner;
                    ptrNext         = winner;
                    holdCntNext     = '0;
                end
            end
            GRANT: begin
                if (!bus.TxReq[gntId]) begin
                    gntNext = '0;
                end else if (timeoutHit) begin
                    gntNext            = '0;
                    holdTimeoutNext    = 1'b1;
                    lockoutNext[gntId] = 1'b1;
                end else if (holdCnt != HOLD_LAST) begin
                    holdCntNext = holdCnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Wire-side mux. It keeps showing the last grantee's lane while idle.
    assign bus.TxBits        = lane[gntId];
    assign bus.TxCtl         = bus.TxCtrlIn[gntId];
    assign bus.TxFSRate      = bus.TxFSRateIn[gntId];
    assign bus.USBWireWEn    = bus.TxWEnIn[gntId] & (|gnt);
    assign bus.USBWireRdyOut = bus.USBWireRdyIn;
    assign bus.TxGnt         = gnt;
    assign bus.GntId         = gntId;
    assign bus.GntActive     = |gnt;
    assign bus.HoldTimeout   = holdTimeout;
endmodule

// File: tb/tb_usb_tx_wire_arbiter_n.sv
// Directed bench for the transmit wire arbiter. It uses three instances:
// a 2-way fixed arbiter with a watchdog, a 4-way fixed arbiter and a
// 4-way round-robin arbiter.
module tb_usb_tx_wire_arbiter_n;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   gnt0Cycles;
    int   pulses;

    always #5 clk = ~clk;

    usb_tx_wire_arbiter_n_if #(.NUM_REQ(2), .BITS_W(2)) bus2 ();
    usb_tx_wire_arbiter_n_if #(.NUM_REQ(4), .BITS_W(2)) bus4f ();
    usb_tx_wire_arbiter_n_if #(.NUM_REQ(4), .BITS_W(2)) bus4r ();

    usb_tx_wire_arbiter_n #(.NUM_REQ(2), .BITS_W(2), .ROUND_ROBIN(0), .MAX_HOLD(5)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );
    usb_tx_wire_arbiter_n #(.NUM_REQ(4), .BITS_W(2), .ROUND_ROBIN(0), .MAX_HOLD(0)) dut4f (
        .clk(clk), .rst(rst), .bus(bus4f)
    );
    usb_tx_wire_arbiter_n #(.NUM_REQ(4), .BITS_W(2), .ROUND_ROBIN(1), .MAX_HOLD(0)) dut4r (
        .clk(clk), .rst(rst), .bus(bus4r)
    );

    // Compare one observed value against its expected value and log the outcome.
    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock. Outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus2.TxReq = '0;  bus2.TxDataIn = '0;  bus2.TxCtrlIn = '0;
        bus2.TxFSRateIn = '0;  bus2.TxWEnIn = '0;  bus2.USBWireRdyIn = 1'b0;
        bus4f.TxReq = '0; bus4f.TxDataIn = '0; bus4f.TxCtrlIn = '0;
        bus4f.TxFSRateIn = '0; bus4f.TxWEnIn = '0; bus4f.USBWireRdyIn = 1'b0;
        bus4r.TxReq = '0; bus4r.TxDataIn = '0; bus4r.TxCtrlIn = '0;
        bus4r.TxFSRateIn = '0; bus4r.TxWEnIn = '0; bus4r.USBWireRdyIn = 1'b0;

        // Reset state.
        step();
        checkVal("rst_gnt",   32'(bus2.TxGnt), 32'h0);
        checkVal("rst_id",    32'(bus2.GntId), 32'h0);
        checkVal("rst_act",   32'(bus2.GntActive), 32'h0);
        checkVal("rst_to",    32'(bus2.HoldTimeout), 32'h0);
        checkVal("rst_wen",   32'(bus2.USBWireWEn), 32'h0);

        // First grant: INIT absorbs one cycle, so the grant appears two edges after release.
        rst = 1'b0;
        bus2.TxReq      = 2'b01;
        bus2.TxDataIn   = 4'b0110;   // lane0 = 2'b10, lane1 = 2'b01
        bus2.TxCtrlIn   = 2'b10;
        bus2.TxFSRateIn = 2'b01;
        bus2.TxWEnIn    = 2'b11;
        step();
        checkVal("init_gnt",  32'(bus2.TxGnt), 32'h0);
        step();
        checkVal("g0_gnt",    32'(bus2.TxGnt), 32'h1);
        checkVal("g0_id",     32'(bus2.GntId), 32'h0);
        checkVal("g0_bits",   32'(bus2.TxBits), 32'h2);
        checkVal("g0_ctl",    32'(bus2.TxCtl), 32'h0);
        checkVal("g0_fs",     32'(bus2.TxFSRate), 32'h1);
        checkVal("g0_wen",    32'(bus2.USBWireWEn), 32'h1);
        bus2.TxReq = 2'b00;
        step();
        checkVal("drop_gnt",  32'(bus2.TxGnt), 32'h0);
        checkVal("idle_wen",  32'(bus2.USBWireWEn), 32'h0);
        checkVal("idle_bits", 32'(bus2.TxBits), 32'h2);

        // Ready passthrough is combinational.
        bus2.USBWireRdyIn = 1'b1;
        #1 checkVal("rdy_hi", 32'(bus2.USBWireRdyOut), 32'h1);
        bus2.USBWireRdyIn = 1'b0;
        #1 checkVal("rdy_lo", 32'(bus2.USBWireRdyOut), 32'h0);

        // Watchdog: requester 0 is cut off after 5 cycles, then requester 1 wins.
        gnt0Cycles = 0;
        pulses     = 0;
        bus2.TxReq = 2'b11;
        for (int c = 0; c < 7; c++) begin
            step();
            if (bus2.TxGnt[0]) gnt0Cycles++;
            if (bus2.HoldTimeout) pulses++;
        end
        checkVal("wd_cycles", 32'(gnt0Cycles), 32'd5);
        checkVal("wd_pulses", 32'(pulses), 32'd1);
        checkVal("wd_next",   32'(bus2.TxGnt), 32'h2);
        checkVal("wd_id",     32'(bus2.GntId), 32'h1);
        checkVal("g1_ctl",    32'(bus2.TxCtl), 32'h1);
        checkVal("g1_fs",     32'(bus2.TxFSRate), 32'h0);
        bus2.TxReq = 2'b01;
        step();
        checkVal("wd_drop1",  32'(bus2.TxGnt), 32'h0);
        step();
        checkVal("lock_a",    32'(bus2.TxGnt), 32'h0);
        step();
        checkVal("lock_b",    32'(bus2.TxGnt), 32'h0);
        bus2.TxReq = 2'b00;
        step();
        bus2.TxReq = 2'b01;
        step();
        checkVal("unlock",    32'(bus2.TxGnt), 32'h1);

        // A non-grantee write enable must not reach the wire.
        bus2.TxWEnIn = 2'b10;
        #1 checkVal("wen_other", 32'(bus2.USBWireWEn), 32'h0);
        bus2.TxWEnIn = 2'b01;
        #1 checkVal("wen_own",   32'(bus2.USBWireWEn), 32'h1);

        // Reset during a grant to requester 1.
        bus2.TxReq = 2'b00;
        step();
        bus2.TxReq = 2'b10;
        step();
        checkVal("pre_rst_id", 32'(bus2.GntId), 32'h1);
        rst = 1'b1;
        step();
        checkVal("mr_gnt",    32'(bus2.TxGnt), 32'h0);
        checkVal("mr_id",     32'(bus2.GntId), 32'h0);
        checkVal("mr_to",     32'(bus2.HoldTimeout), 32'h0);
        rst = 1'b0;
        step();
        checkVal("mr_init",   32'(bus2.TxGnt), 32'h0);
        step();
        checkVal("mr_resume", 32'(bus2.TxGnt), 32'h2);

        // Fixed priority with 4 requesters.
        bus4f.TxDataIn = 8'b11100100;   // lane i carries value i
        bus4f.TxReq    = 4'b1010;
        step();
        checkVal("fx_gnt1",   32'(bus4f.TxGnt), 32'h2);
        checkVal("fx_id1",    32'(bus4f.GntId), 32'h1);
        checkVal("fx_bits1",  32'(bus4f.TxBits), 32'h1);
        step();
        checkVal("fx_nopre",  32'(bus4f.TxGnt), 32'h2);
        bus4f.TxReq = 4'b1000;
        step();
        checkVal("fx_idle",   32'(bus4f.TxGnt), 32'h0);
        checkVal("fx_idleid", 32'(bus4f.GntId), 32'h1);
        step();
        checkVal("fx_gnt3",   32'(bus4f.TxGnt), 32'h8);
        checkVal("fx_id3",    32'(bus4f.GntId), 32'h3);
        checkVal("fx_bits3",  32'(bus4f.TxBits), 32'h3);

        // Round-robin rotation: each grantee drops after 3 cycles and re-requests.
        bus4r.TxReq = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            step();
            checkVal("rr_gnt",  32'(bus4r.TxGnt), 32'(1) << (g % 4));
            checkVal("rr_id",   32'(bus4r.GntId), 32'(g % 4));
            step();
            step();
            checkVal("rr_hold", 32'(bus4r.TxGnt), 32'(1) << (g % 4));
            bus4r.TxReq[g % 4] = 1'b0;
            step();
            checkVal("rr_idle", 32'(bus4r.GntActive), 32'h0);
            bus4r.TxReq[g % 4] = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
